muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M execute unit that succeeds the single-cycle combinational MUL/DIV/REM path in the EX stage.
- Covers all eight M-extension ops, including MULH, MULHSU and MULHU, which the previous path lacked.
- Multiply uses a fixed-latency pipelined path; divide uses an iterative radix-2 engine.
- Sits beside the base ALU in EX. The hazard unit stalls the pipeline while `busy` is high.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8.
- MUL_LAT, 2, multiply latency in cycles from accept to `out_valid`; legal range 1–4.
- DIV_EARLY, 1, when 1, divide-by-zero and signed overflow complete in 1 cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  3  funct3 of the M instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- flush  in  1  kill the in-flight op (branch mispredict or trap)
- busy  out  1  op in flight; drives the EX stall
- out_valid  out  1  one-cycle result pulse
- result  out  XLEN  result; held until the next accept

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE
  - busy = 0, out_valid = 0, result = 0
  - in_ready = 1 from the first cycle after `rst` deasserts; in_ready = 0 while `rst` is high.
- Accept: a request is accepted when `in_valid & in_ready` at a rising edge. `op`, `a` and `b` are registered on accept. `in_valid` while not ready is ignored; it is neither queued nor lost-flagged.
- States: IDLE, MUL, DIV_INIT, DIV_ITER, DIV_FIX, DONE.
  - IDLE → MUL on accept with op[2]=0.
  - IDLE → DIV_INIT on accept with op[2]=1.
  - MUL → DONE after MUL_LAT−1 cycles; MUL_LAT=1 goes directly to DONE.
  - DIV_INIT: computes operand magnitudes and loads the counter with XLEN. Goes to DONE if an early case applies, else to DIV_ITER.
  - DIV_ITER: one quotient bit per cycle; counter decrements; → DIV_FIX when the counter reaches 0.
  - DIV_FIX: applies sign correction; → DONE.
  - DONE: out_valid=1 for exactly one cycle; → IDLE.
- Latency (accept edge to out_valid high):
  - MUL: MUL_LAT.
  - Normal divide: XLEN+3 (35 at XLEN=32).
  - Early divide: 2.
- Multiply arithmetic: form the 2·XLEN product of the sign/zero-extended operands.
  - MUL returns the low half.
  - MULH treats both operands as signed and returns the high half.
  - MULHSU treats `a` as signed and `b` as unsigned, high half.
  - MULHU treats both as unsigned, high half.
- Divide arithmetic:
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Boundary cases:
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - a = −2^(XLEN−1), b = −1 (DIV only): DIV → a; REM → 0.
  - With DIV_EARLY=0, both cases run the full iteration and produce identical values.
- busy = 1 in every state except IDLE. in_ready = ~busy & ~rst. No back-to-back accept in the DONE cycle.
- flush:
  - In any state other than IDLE, flush forces IDLE at the next edge. out_valid stays 0 and `result` is unchanged.
  - flush in the same cycle as an accept cancels the accept.
  - flush has no effect in IDLE.
- rst mid-operation: abandons the op and applies all reset values. No out_valid is produced for the aborted op.
- Output: `result` updates only on the DONE-entry edge and is stable between out_valid pulses.

Decomposition:
- Shared package `muldiv_pkg`: op encoding constants (MUL…REMU), state encoding, XLEN default.
- Sub-module `muldiv_div_core`: the radix-2 restoring iteration.
  - Inputs: magnitudes, load, step.
  - Outputs: quotient and remainder registers, done at count 0.
- The multiply pipeline and sign fixup stay in the top level.

Test Plan:
- After reset, MUL a=7 b=−3, MUL_LAT=2 → out_valid exactly 2 cycles after accept, result=0xFFFFFFEB; busy high for both cycles.
- MULH a=0x80000000 b=0x80000000 → 0x40000000; MULHSU a=−1 b=0xFFFFFFFF → 0xFFFFFFFF; MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- DIV a=−20 b=3 → −6 (0xFFFFFFFA) after 35 cycles; REM same operands → −2; DIVU a=20 b=3 → 6; REMU → 2.
- DIV a=5 b=0 → 0xFFFFFFFF at 2 cycles; REMU a=5 b=0 → 5; DIV a=0x80000000 b=0xFFFFFFFF → 0x80000000; REM of the same → 0.
- DIVU started, flush asserted at iteration 10 → IDLE next cycle, no out_valid, `result` keeps its prior value; a new MUL then completes normally.
- Issue `in_valid` every cycle for 40 cycles → only requests seen with in_ready=1 are accepted; rst asserted mid-divide → busy=0, out_valid=0, result=0 the following cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 op codes,
// FSM state codes and the default datapath width.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // funct3 of the M-extension instructions
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_MUL      = 3'd1;
    localparam state_t ST_DIV_INIT = 3'd2;
    localparam state_t ST_DIV_ITER = 3'd3;
    localparam state_t ST_DIV_FIX  = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    // Divide-class ops are the upper half of the funct3 space.
    function automatic logic is_div_op(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes. One quotient bit per
// step; done_o flags the step that brings the bit counter to zero.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o,
    output logic            done_o
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   rem_sh;
    logic            fits;

    // Shift-subtract step; the partial remainder is always below the divisor,
    // so the difference fits in XLEN bits whenever the subtraction succeeds.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        fits   = rem_sh >= {1'b0, div_q};
        quo_d  = quo_q;
        rem_d  = rem_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            div_d = divisor_i;
            cnt_d = CW'(XLEN);
        end else if (step_i) begin
            rem_d = fits ? (rem_sh[XLEN-1:0] - div_q) : rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], fits};
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign done_o = step_i & (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: pipelined fixed-latency multiply and an
// iterative divide with sign fixup. busy stalls EX while an op is in flight.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request, in_ready high
// MUL      | multiply pipeline draining (MUL_LAT-1 cycles)
// DIV_INIT | magnitudes formed, divider loaded, early cases resolved
// DIV_ITER | one quotient bit per cycle
// DIV_FIX  | sign correction of quotient/remainder
// DONE     | out_valid pulse, result just updated
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int MUL_LAT   = 2,
    parameter int DIV_EARLY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] INT_MIN      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [1:0]      MUL_CNT_INIT = (MUL_LAT >= 2) ? 2'(MUL_LAT - 2) : 2'd0;

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [1:0]      mul_cnt_q, mul_cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            accept;

    logic [XLEN-1:0] mul_now, mul_final;

    logic            div_signed, div_is_rem, a_neg, b_neg, b_zero, ovf, early_go;
    logic [XLEN-1:0] mag_a, mag_b, early_res, fix_res, quo, rem;
    logic            div_done;

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = ~busy & ~rst;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign accept    = in_valid & in_ready & ~flush;

    // Full 2*XLEN product of sign/zero-extended operands; two's-complement
    // wraparound makes an unsigned multiply of the extended values exact.
    function automatic logic [XLEN-1:0] mul_select(input logic [2:0] f,
                                                   input logic [XLEN-1:0] x,
                                                   input logic [XLEN-1:0] y);
        logic            sx, sy;
        logic [2*XLEN-1:0] xe, ye, p;
        sx = (f != OP_MULHU);
        sy = (f != OP_MULHU) & (f != OP_MULHSU);
        xe = {{XLEN{sx & x[XLEN-1]}}, x};
        ye = {{XLEN{sy & y[XLEN-1]}}, y};
        p  = xe * ye;
        return (f == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Single-cycle latency must multiply straight off the request inputs.
    assign mul_now = (MUL_LAT == 1) ? mul_select(op, a, b) : mul_select(op_q, a_q, b_q);

    if (MUL_LAT > 2) begin : g_mul_pipe
        logic [XLEN-1:0] pipe_q [MUL_LAT-2];

        // Delay line that stretches the product out to MUL_LAT cycles
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < MUL_LAT - 2; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= mul_now;
                for (int i = 1; i < MUL_LAT - 2; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign mul_final = pipe_q[MUL_LAT-3];
    end else begin : g_mul_direct
        assign mul_final = mul_now;
    end

    // Divide operand conditioning, early cases and sign fixup
    always_comb begin
        div_signed = ~((op_q == OP_DIVU) | (op_q == OP_REMU));
        div_is_rem = (op_q == OP_REM) | (op_q == OP_REMU);
        a_neg      = div_signed & a_q[XLEN-1];
        b_neg      = div_signed & b_q[XLEN-1];
        mag_a      = a_neg ? -a_q : a_q;
        mag_b      = b_neg ? -b_q : b_q;
        b_zero     = (b_q == '0);
        ovf        = div_signed & (a_q == INT_MIN) & (b_q == '1);
        early_go   = (DIV_EARLY != 0) & (b_zero | ovf);
        if (b_zero) early_res = div_is_rem ? a_q : '1;
        else        early_res = div_is_rem ? '0 : a_q;
        // A zero divisor yields an all-ones quotient that must not be negated.
        if (div_is_rem) fix_res = a_neg ? -rem : rem;
        else            fix_res = ((a_neg ^ b_neg) & ~b_zero) ? -quo : quo;
    end

    muldiv_div_core #(
        .XLEN(XLEN)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == ST_DIV_INIT),
        .step_i    (state_q == ST_DIV_ITER),
        .dividend_i(mag_a),
        .divisor_i (mag_b),
        .quo_o     (quo),
        .rem_o     (rem),
        .done_o    (div_done)
    );

    // Next-state, multiply countdown and result capture on DONE entry
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mul_cnt_d = MUL_CNT_INIT;
                    if (is_div_op(op))     state_d = ST_DIV_INIT;
                    else if (MUL_LAT == 1) state_d = ST_DONE;
                    else                   state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_cnt_q == 2'd0) state_d = ST_DONE;
                else                   mul_cnt_d = mul_cnt_q - 2'd1;
            end
            ST_DIV_INIT: state_d = early_go ? ST_DONE : ST_DIV_ITER;
            ST_DIV_ITER: if (div_done) state_d = ST_DIV_FIX;
            ST_DIV_FIX:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (flush && (state_q != ST_IDLE)) state_d = ST_IDLE;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            case (state_q)
                ST_IDLE, ST_MUL: result_d = mul_final;
                ST_DIV_INIT:     result_d = early_res;
                default:         result_d = fix_res;
            endcase
        end
    end

    // Control and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mul_cnt_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            result_q  <= result_d;
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32, MUL_LAT=2, DIV_EARLY=1.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        in_ready, busy, out_valid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN(32),
        .MUL_LAT(2),
        .DIV_EARLY(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .out_valid(out_valid),
        .result   (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (in_ready !== 1'b1 && w < 60) begin
            tick();
            w++;
        end
        check({tag, " ready"}, in_ready, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        int n;
        wait_ready(tag);
        op = f; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, " busy"}, busy, 32'd1);
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, " valid"}, out_valid, 32'd1);
        check({tag, " busy_done"}, busy, 32'd1);
        check({tag, " latency"}, n, exp_lat);
        check({tag, " result"}, result, exp_res);
        tick();
        check({tag, " pulse_end"}, out_valid, 32'd0);
        check({tag, " idle"}, busy, 32'd0);
        check({tag, " held"}, result, exp_res);
    endtask

    initial begin
        int rdy, pulses;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", in_ready, 32'd0);
        check("rst busy", busy, 32'd0);
        check("rst out_valid", out_valid, 32'd0);
        check("rst result", result, 32'd0);
        rst = 1'b0;
        tick();
        check("post-rst in_ready", in_ready, 32'd1);
        check("post-rst result", result, 32'd0);

        // multiply family
        run_op(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, "mul");
        run_op(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2, "mulh");
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, "mulhsu");
        run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, "mulhu");

        // iterative divide
        run_op(OP_DIV,  32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 35, "div");
        run_op(OP_REM,  32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 35, "rem");
        run_op(OP_DIVU, 32'd20,       32'd3, 32'd6,        35, "divu");
        run_op(OP_REMU, 32'd20,       32'd3, 32'd2,        35, "remu");
        run_op(OP_DIVU, 32'hFFFFFFEC, 32'd3, 32'h5555554E, 35, "divu big");

        // early cases
        run_op(OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 2, "div0");
        run_op(OP_REMU, 32'd5,        32'd0,        32'd5,        2, "remu0");
        run_op(OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2, "rem0 neg");
        run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div ovf");
        run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        2, "rem ovf");

        // flush mid-divide keeps the prior result
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, "prior");
        wait_ready("flush");
        op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("flush pre busy", busy, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", busy, 32'd0);
        check("flush out_valid", out_valid, 32'd0);
        check("flush result", result, 32'hFFFFFFFE);
        check("flush in_ready", in_ready, 32'd1);
        pulses = 0;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        check("flush no pulse", pulses, 32'd0);
        check("flush result kept", result, 32'hFFFFFFFE);

        // flush together with a request cancels the accept
        op = OP_MUL; a = 32'd2; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush cancel busy", busy, 32'd0);
        pulses = 0;
        repeat (4) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        check("flush cancel no pulse", pulses, 32'd0);
        run_op(OP_MUL, 32'd6, 32'd7, 32'd42, 2, "mul after flush");

        // in_valid held for 40 cycles: an accept every third cycle
        op = OP_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        rdy = 0; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) rdy++;
            if (out_valid === 1'b1) begin
                pulses++;
                check("stream result", result, 32'd15);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        check("stream ready count", rdy, 32'd14);
        check("stream pulse count", pulses, 32'd14);

        // reset in the middle of a divide
        wait_ready("rst mid");
        op = OP_DIV; a = 32'hFFFFFFEC; b = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("rst mid busy", busy, 32'd0);
        check("rst mid out_valid", out_valid, 32'd0);
        check("rst mid result", result, 32'd0);
        check("rst mid in_ready", in_ready, 32'd0);
        rst = 1'b0;
        tick();
        check("rst mid ready after", in_ready, 32'd1);
        pulses = 0;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        check("rst mid no pulse", pulses, 32'd0);
        run_op(OP_DIVU, 32'd20, 32'd3, 32'd6, 35, "divu after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
